// File: rtl/led_scan_if.sv
// Scanned 7-segment display bus: segment lines {dp,g,f,e,d,c,b,a} and digit selects, both active-low.
// The driver (led_mux side) uses master; the receiving decoder uses slave.
interface led_scan_if #(
    parameter int N_DIGITS = 8
);
    logic [7:0]          led_out;
    logic [N_DIGITS-1:0] led_sel;

    modport master (output led_out, output led_sel);
    modport slave  (input  led_out, input  led_sel);
endinterface

// File: rtl/led_scan_decoder.sv
// Purpose: de-multiplex a scanned 7-segment bus back into per-digit nibble/blank/dp registers.
// Latency: 2 + STABLE_CYCLES clk from a bus change to the captured digit; frame_done one cycle later.
// Backpressure: none, the bus is sampled every cycle. Optional digit_chg pulses via macro LED_SCAN_CHG_EN.
module led_scan_decoder #(
    parameter int N_DIGITS      = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    led_scan_if.slave             bus,
    input  logic                  clr,
    output logic [4*N_DIGITS-1:0] digit_vals,
    output logic [N_DIGITS-1:0]   digit_blank,
    output logic [N_DIGITS-1:0]   digit_dp,
    output logic                  frame_done,
    output logic                  pattern_err,
    output logic                  err_sticky,
    output logic [N_DIGITS-1:0]   digit_chg
);

    typedef struct packed {
        logic [N_DIGITS-1:0] sel;
        logic [7:0]          seg;
    } scan_t;

    localparam logic [3:0]          CNT_MAX    = 4'(STABLE_CYCLES - 1);
    localparam logic [3:0]          CNT_CAP    = 4'(STABLE_CYCLES - 2);
    localparam scan_t               SCAN_IDLE  = '1;
    localparam logic [N_DIGITS-1:0] ALL_DIGITS = '1;
    localparam logic [N_DIGITS-1:0] SEL_ONE    = N_DIGITS'(1);

    // Returns {hit, nibble} for the raw active-low gfedcba pattern.
    function automatic logic [4:0] seg_decode(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h40:   r = {1'b1, 4'h0};
            7'h79:   r = {1'b1, 4'h1};
            7'h24:   r = {1'b1, 4'h2};
            7'h30:   r = {1'b1, 4'h3};
            7'h19:   r = {1'b1, 4'h4};
            7'h12:   r = {1'b1, 4'h5};
            7'h02:   r = {1'b1, 4'h6};
            7'h78:   r = {1'b1, 4'h7};
            7'h00:   r = {1'b1, 4'h8};
            7'h10:   r = {1'b1, 4'h9};
            7'h08:   r = {1'b1, 4'hA};
            7'h03:   r = {1'b1, 4'hB};
            7'h46:   r = {1'b1, 4'hC};
            7'h21:   r = {1'b1, 4'hD};
            7'h06:   r = {1'b1, 4'hE};
            7'h0E:   r = {1'b1, 4'hF};
            default: r = 5'd0;
        endcase
        return r;
    endfunction

    scan_t                  sync1_q, sync1_d;
    scan_t                  sync2_q, sync2_d;
    scan_t                  sp_prev_q, sp_prev_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [4*N_DIGITS-1:0]  vals_q, vals_d;
    logic [N_DIGITS-1:0]    blank_q, blank_d;
    logic [N_DIGITS-1:0]    dp_q, dp_d;
    logic [N_DIGITS-1:0]    mask_q, mask_d;
    logic                   frame_done_q, frame_done_d;
    logic                   pattern_err_q, pattern_err_d;
    logic                   err_sticky_q, err_sticky_d;

    logic                   sp_same;
    logic                   capture;
    logic [N_DIGITS-1:0]    sel_n;
    logic                   sel_idle;
    logic                   sel_onehot;
    logic                   err_now;
    logic [4:0]             dec;

    always_comb begin
        sync1_d   = {bus.led_sel, bus.led_out};
        sync2_d   = sync1_q;
        sp_prev_d = sync2_q;

        // One capture per stable interval: the counter parks at CNT_MAX, past CNT_CAP.
        sp_same = (sync2_q == sp_prev_q);
        if (!sp_same) begin
            cnt_d = 4'd0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 4'd1;
        end
        capture = sp_same && (cnt_q == CNT_CAP);

        sel_n      = ~sync2_q.sel;
        sel_idle   = (sel_n == '0);
        sel_onehot = !sel_idle && ((sel_n & (sel_n - SEL_ONE)) == '0);
        dec        = seg_decode(sync2_q.seg[6:0]);

        vals_d       = vals_q;
        blank_d      = blank_q;
        dp_d         = dp_q;
        err_now      = 1'b0;
        frame_done_d = (mask_q == ALL_DIGITS) && !clr;
        mask_d       = (clr || (mask_q == ALL_DIGITS)) ? '0 : mask_q;

        if (capture && !sel_idle) begin
            if (!sel_onehot) begin
                err_now = 1'b1;
            end else begin
                for (int i = 0; i < N_DIGITS; i++) begin
                    if (sel_n[i]) begin
                        dp_d[i]   = ~sync2_q.seg[7];
                        mask_d[i] = 1'b1;
                        if (sync2_q.seg[6:0] == 7'h7F) begin
                            vals_d[4*i +: 4] = 4'h0;
                            blank_d[i]       = 1'b1;
                        end else if (dec[4]) begin
                            vals_d[4*i +: 4] = dec[3:0];
                            blank_d[i]       = 1'b0;
                        end else begin
                            err_now = 1'b1;
                        end
                    end
                end
            end
        end

        pattern_err_d = err_now;
        // A new error outranks a simultaneous clr.
        err_sticky_d  = (err_sticky_q && !clr) || err_now;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q       <= SCAN_IDLE;
            sync2_q       <= SCAN_IDLE;
            sp_prev_q     <= SCAN_IDLE;
            cnt_q         <= 4'd0;
            vals_q        <= '0;
            blank_q       <= '1;
            dp_q          <= '0;
            mask_q        <= '0;
            frame_done_q  <= 1'b0;
            pattern_err_q <= 1'b0;
            err_sticky_q  <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            sp_prev_q     <= sp_prev_d;
            cnt_q         <= cnt_d;
            vals_q        <= vals_d;
            blank_q       <= blank_d;
            dp_q          <= dp_d;
            mask_q        <= mask_d;
            frame_done_q  <= frame_done_d;
            pattern_err_q <= pattern_err_d;
            err_sticky_q  <= err_sticky_d;
        end
    end

`ifdef LED_SCAN_CHG_EN
    logic [N_DIGITS-1:0] chg_q, chg_d;

    // The output registers double as the shadow of the previous capture.
    always_comb begin
        chg_d = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            chg_d[i] = capture && sel_onehot && sel_n[i] &&
                       ({vals_d[4*i +: 4], blank_d[i], dp_d[i]} !=
                        {vals_q[4*i +: 4], blank_q[i], dp_q[i]});
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chg_q <= '0;
        end else begin
            chg_q <= chg_d;
        end
    end

    assign digit_chg = chg_q;
`else
    assign digit_chg = '0;
`endif

    assign digit_vals  = vals_q;
    assign digit_blank = blank_q;
    assign digit_dp    = dp_q;
    assign frame_done  = frame_done_q;
    assign pattern_err = pattern_err_q;
    assign err_sticky  = err_sticky_q;

endmodule
